q_episode_scheduler: RTL

//  Drives Q-learning episodes on a ROWS x COLS grid world. Walks the agent, reads Q(s,*) through a
//  1-cycle-latency read port and picks an epsilon-greedy action. It then computes next state and

---
 rtl/q_episode_scheduler_if.sv | 36 +++
 rtl/q_episode_scheduler.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/q_episode_scheduler_if.sv
// Bus between the episode scheduler and its environment.
//   q_rd_addr / q_rd_data : Q-table read port. Data is valid the cycle after the address.
//   upd_valid / upd_ready : transition handshake to the Q-update engine.
//   row, col, action, next_row, next_col, reward : the transition payload.
// The master modport is the scheduler side. The slave modport is the Q-table/update-engine side.
interface q_episode_scheduler_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] q_rd_addr;
  logic [DATA_WIDTH-1:0] q_rd_data;
  logic                  upd_valid;
  logic                  upd_ready;
  logic [2:0]            row;
  logic [2:0]            col;
  logic [1:0]            action;
  logic [2:0]            next_row;
  logic [2:0]            next_col;
  logic [7:0]            reward;

  modport master (
    output q_rd_addr,
    input  q_rd_data,
    output upd_valid,
    input  upd_ready,
    output row, col, action, next_row, next_col, reward
  );

  modport slave (
    input  q_rd_addr,
    output q_rd_data,
    input  upd_valid,
    output upd_ready,
    input  row, col, action, next_row, next_col, reward
  );
endinterface

// File: rtl/q_episode_scheduler.sv
// Q-learning episode scheduler for a ROWS x COLS grid world.
// Each step does the following:
//   1. Reads Q(s,0..3).
//   2. Picks an epsilon-greedy action from an 8-bit Fibonacci LFSR.
//   3. Computes the clamped next state and the reward.
//   4. Hands the transition to the update engine over bus.upd_valid/upd_ready.
// A run executes NUM_EPISODES episodes. Each episode starts at (0,0).
// Ports:
//   clk, rst    : clock and asynchronous active-high reset
//   start       : one-cycle pulse that starts a run; ignored while busy
//   busy        : high from the accepted start until done
//   done        : one-cycle pulse after the final update handshake of the run
//   episode_cnt : number of completed episodes in this run
//   step_cnt    : number of steps issued in the current episode
//   bus         : Q read port and transition handshake (master side)
module q_episode_scheduler #(
  parameter int         ROWS         = 5,
  parameter int         COLS         = 5,
  parameter int         ACTIONS      = 4,
  parameter int         ADDR_WIDTH   = 7,
  parameter int         DATA_WIDTH   = 8,
  parameter int         GOAL_ROW     = 4,
  parameter int         GOAL_COL     = 4,
  parameter int         MAX_STEPS    = 32,
  parameter int         NUM_EPISODES = 16,
  parameter logic [7:0] EPS_THRESH   = 8'd26,
  parameter logic [7:0] LFSR_SEED    = 8'hA5,
  parameter logic [7:0] REWARD_GOAL  = 8'd100,
  parameter logic [7:0] REWARD_STEP  = 8'd0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic [7:0]                  episode_cnt,
  output logic [7:0]                  step_cnt,
  q_episode_scheduler_if.master       bus
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_SELECT, S_ISSUE, S_ADVANCE} state_t;

  state_t                state;
  logic [2:0]            rd_idx;
  logic [DATA_WIDTH-1:0] qv [4];
  logic [7:0]            lfsr;

  logic [ADDR_WIDTH-1:0] q_rd_addr_r;
  logic                  upd_valid_r;
  logic [2:0]            row_r, col_r, next_row_r, next_col_r;
  logic [1:0]            action_r;
  logic [7:0]            reward_r;

  logic [7:0]            lfsr_next;
  logic [1:0]            best_a;
  logic [DATA_WIDTH-1:0] best_v;
  logic [1:0]            sel_action;
  logic [2:0]            sel_row, sel_col;
  logic                  sel_goal;
  logic [7:0]            step_inc, ep_inc;
  logic                  ep_end, run_end;
  logic [2:0]            adv_row, adv_col;

  assign bus.q_rd_addr = q_rd_addr_r;
  assign bus.upd_valid = upd_valid_r;
  assign bus.row       = row_r;
  assign bus.col       = col_r;
  assign bus.action    = action_r;
  assign bus.next_row  = next_row_r;
  assign bus.next_col  = next_col_r;
  assign bus.reward    = reward_r;

  function automatic logic [ADDR_WIDTH-1:0] q_addr(input logic [2:0] r, input logic [2:0] c,
                                                   input logic [1:0] a);
    return ADDR_WIDTH'(r) * ADDR_WIDTH'(COLS * ACTIONS) + ADDR_WIDTH'(c) * ADDR_WIDTH'(ACTIONS)
           + ADDR_WIDTH'(a);
  endfunction

  always_comb begin
    lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

    // Strict greater-than keeps the lowest index on ties.
    best_a = 2'd0;
    best_v = qv[0];
    for (int unsigned i = 1; i < 4; i++) begin
      if (qv[i] > best_v) begin
        best_v = qv[i];
        best_a = 2'(i);
      end
    end
    sel_action = (lfsr_next < EPS_THRESH) ? lfsr_next[1:0] : best_a;

    sel_row = row_r;
    sel_col = col_r;
    case (sel_action)
      2'd0:    if (row_r != 3'd0)           sel_row = row_r - 3'd1;
      2'd1:    if (row_r != 3'(ROWS - 1))   sel_row = row_r + 3'd1;
      2'd2:    if (col_r != 3'd0)           sel_col = col_r - 3'd1;
      default: if (col_r != 3'(COLS - 1))   sel_col = col_r + 3'd1;
    endcase
    sel_goal = (sel_row == 3'(GOAL_ROW)) && (sel_col == 3'(GOAL_COL));

    step_inc = (step_cnt == 8'hFF) ? 8'hFF : step_cnt + 8'd1;
    ep_inc   = (episode_cnt == 8'hFF) ? 8'hFF : episode_cnt + 8'd1;
    ep_end   = ((next_row_r == 3'(GOAL_ROW)) && (next_col_r == 3'(GOAL_COL)))
               || (int'(step_inc) >= MAX_STEPS);
    run_end  = ep_end && (int'(ep_inc) >= NUM_EPISODES);
    adv_row  = ep_end ? 3'd0 : next_row_r;
    adv_col  = ep_end ? 3'd0 : next_col_r;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      rd_idx      <= '0;
      for (int unsigned i = 0; i < 4; i++) qv[i] <= '0;
      lfsr        <= LFSR_SEED;
      busy        <= 1'b0;
      done        <= 1'b0;
      episode_cnt <= '0;
      step_cnt    <= '0;
      q_rd_addr_r <= '0;
      upd_valid_r <= 1'b0;
      row_r       <= '0;
      col_r       <= '0;
      action_r    <= '0;
      next_row_r  <= '0;
      next_col_r  <= '0;
      reward_r    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy        <= 1'b1;
            episode_cnt <= '0;
            step_cnt    <= '0;
            row_r       <= '0;
            col_r       <= '0;
            q_rd_addr_r <= '0;
            rd_idx      <= '0;
            state       <= S_READ;
          end
        end
        // The address for action k is on the port in READ cycle k.
        // Its data is captured at the end of cycle k+1, so five cycles cover four reads.
        S_READ: begin
          if (rd_idx != 3'd0) qv[2'(rd_idx - 3'd1)] <= bus.q_rd_data;
          if (rd_idx < 3'd3) q_rd_addr_r <= q_addr(row_r, col_r, 2'(rd_idx) + 2'd1);
          if (rd_idx == 3'd4) begin
            rd_idx <= '0;
            state  <= S_SELECT;
          end else begin
            rd_idx <= rd_idx + 3'd1;
          end
        end
        S_SELECT: begin
          lfsr        <= lfsr_next;
          action_r    <= sel_action;
          next_row_r  <= sel_row;
          next_col_r  <= sel_col;
          reward_r    <= sel_goal ? REWARD_GOAL : REWARD_STEP;
          upd_valid_r <= 1'b1;
          state       <= S_ISSUE;
        end
        S_ISSUE: begin
          if (upd_valid_r && bus.upd_ready) begin
            upd_valid_r <= 1'b0;
            state       <= S_ADVANCE;
          end
        end
        S_ADVANCE: begin
          row_r <= adv_row;
          col_r <= adv_col;
          if (ep_end) begin
            episode_cnt <= ep_inc;
            step_cnt    <= '0;
          end else begin
            step_cnt <= step_inc;
          end
          if (run_end) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            q_rd_addr_r <= q_addr(adv_row, adv_col, 2'd0);
            rd_idx      <= '0;
            state       <= S_READ;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
